// File: rtl/ysyx_22050243_ifu_prefetch_pkg.sv
// rtl/ysyx_22050243_ifu_prefetch_pkg.sv - shared constants for the prefetching fetch unit
package ysyx_22050243_ifu_prefetch_pkg;

    localparam int          IFU_XLEN     = 64;
    localparam int          IFU_ILEN     = 32;
    localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

    // Bubble inserted by consumers when no fetched instruction is available.
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    // Fetch-entry field widths.
    localparam int          FE_PC_W      = IFU_XLEN;
    localparam int          FE_DATA_W    = IFU_ILEN;

endpackage

// File: rtl/ysyx_22050243_ifu_prefetch_fetch_ring.sv
// rtl/ysyx_22050243_ifu_prefetch_fetch_ring.sv - in-order pc/instruction ring with alloc/fill/pop pointers
module ysyx_22050243_fetch_ring
    import ysyx_22050243_ifu_prefetch_pkg::*;
#(
    parameter int XLEN  = FE_PC_W,
    parameter int ILEN  = FE_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       alloc_i,
    input  logic [XLEN-1:0]            alloc_pc_i,
    input  logic                       fill_i,
    input  logic [ILEN-1:0]            fill_data_i,
    input  logic                       pop_i,
    output logic                       head_filled_o,
    output logic [XLEN-1:0]            head_pc_o,
    output logic [ILEN-1:0]            head_data_o,
    output logic [$clog2(DEPTH+1)-1:0] alloc_cnt_o,
    output logic [$clog2(DEPTH+1)-1:0] pending_cnt_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [ILEN-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PW-1:0]    head_q, fill_q, tail_q;
    logic [IW-1:0]    head_idx, fill_idx, tail_idx;

    assign head_idx = head_q[IW-1:0];
    assign fill_idx = fill_q[IW-1:0];
    assign tail_idx = tail_q[IW-1:0];

    always_comb begin
        filled_d = filled_q;
        if (alloc_i) filled_d[tail_idx] = 1'b0;
        if (fill_i)  filled_d[fill_idx] = 1'b1;
        if (pop_i)   filled_d[head_idx] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_q   <= '0;
            fill_q   <= '0;
            tail_q   <= '0;
            filled_q <= '0;
        end else begin
            if (alloc_i) tail_q <= tail_q + PW'(1);
            if (fill_i)  fill_q <= fill_q + PW'(1);
            if (pop_i)   head_q <= head_q + PW'(1);
            filled_q <= filled_d;
        end
    end

    // Payload storage needs no reset: only filled bits qualify it.
    always_ff @(posedge clk_i) begin
        if (alloc_i) pc_q[tail_idx]   <= alloc_pc_i;
        if (fill_i)  data_q[fill_idx] <= fill_data_i;
    end

    assign head_filled_o = filled_q[head_idx];
    assign head_pc_o     = pc_q[head_idx];
    assign head_data_o   = data_q[head_idx];
    assign alloc_cnt_o   = CW'(tail_q - head_q);
    assign pending_cnt_o = CW'(tail_q - fill_q);

endmodule

// File: rtl/ysyx_22050243_ifu_prefetch.sv
// rtl/ysyx_22050243_ifu_prefetch.sv - pipelined instruction fetch with response buffering and redirect flush
module ysyx_22050243_ifu_prefetch
    import ysyx_22050243_ifu_prefetch_pkg::*;
#(
    parameter int              XLEN     = IFU_XLEN,
    parameter int              ILEN     = IFU_ILEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_resp_valid,
    input  logic [ILEN-1:0]            imem_resp_data,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [ILEN-1:0]            inst_data,
    output logic [XLEN-1:0]            inst_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   alloc_cnt, pending_cnt;
    logic [CW:0]     inflight, stale_sum;
    logic            req_fire, resp_live, resp_keep, pop, head_filled;

    assign inflight  = {1'b0, pending_cnt} + {1'b0, drop_cnt_q};
    assign stale_sum = {1'b0, pending_cnt} + {1'b0, drop_cnt_q};

    assign imem_req_valid = !rst && !redirect_valid
                         && (alloc_cnt < CW'(DEPTH))
                         && (inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = rst ? RESET_PC : fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_live = !rst && !redirect_valid && imem_resp_valid;
    assign resp_keep = resp_live && (drop_cnt_q == '0) && (pending_cnt != '0);

    assign inst_valid = head_filled && !redirect_valid && !rst;
    assign pop        = inst_valid && inst_ready;
    assign occupancy  = rst ? '0 : alloc_cnt;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            // Everything still owed by memory becomes stale; a response this cycle is already one of them.
            if (imem_resp_valid && stale_sum != '0) drop_cnt_d = CW'(stale_sum - (CW+1)'(1));
            else                                     drop_cnt_d = CW'(stale_sum);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (resp_live && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid && imem_resp_valid)
            assert (drop_cnt_q != '0 || pending_cnt != '0);
    end

    ysyx_22050243_fetch_ring #(
        .XLEN  (XLEN),
        .ILEN  (ILEN),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (redirect_valid),
        .alloc_i       (req_fire),
        .alloc_pc_i    (fetch_pc_q),
        .fill_i        (resp_keep),
        .fill_data_i   (imem_resp_data),
        .pop_i         (pop),
        .head_filled_o (head_filled),
        .head_pc_o     (inst_pc),
        .head_data_o   (inst_data),
        .alloc_cnt_o   (alloc_cnt),
        .pending_cnt_o (pending_cnt)
    );

endmodule

// File: tb/tb_ysyx_22050243_ifu_prefetch.sv
// tb/tb_ysyx_22050243_ifu_prefetch.sv - self-checking bench for the prefetching fetch unit
module tb_ysyx_22050243_ifu_prefetch;

    localparam int          DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst, redirect_valid, imem_req_ready, imem_resp_valid, inst_ready;
    logic [63:0] redirect_pc, imem_req_addr, inst_pc;
    logic        imem_req_valid, inst_valid;
    logic [31:0] imem_resp_data, inst_data;
    logic [2:0]  occupancy;

    always #5 clk = ~clk;

    ysyx_22050243_ifu_prefetch dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .occupancy       (occupancy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ 32'h13C0_FFEE;
    endfunction

    // Reference: queue of allocated PCs, queue of delivered words, fetch PC, stale count.
    logic [63:0] m_pcs[$];
    logic [31:0] m_data[$];
    logic [63:0] m_fetch;
    int          m_drop;

    // Memory: in-order, one response per cycle, latency lat cycles after acceptance.
    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;
    mreq_t mem_q[$];
    int    lat      = 1;
    int    last_due = -1;
    int    cyc      = 0;
    int    n_fire   = 0;

    initial begin
        int          pending;
        bit          e_req, e_iv, fire, pop, resp, s_rst, s_redir;
        logic [63:0] s_rpc;
        logic [31:0] s_rdata;
        mreq_t       r;
        m_fetch = RST_PC;
        m_drop  = 0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            #2;
            pending = m_pcs.size() - m_data.size();
            e_req = !rst && !redirect_valid && m_pcs.size() < DEPTH && (pending + m_drop) < DEPTH;
            e_iv  = !rst && !redirect_valid && m_data.size() > 0;
            check("mon_req_valid", 64'(imem_req_valid), 64'(e_req));
            check("mon_req_addr", imem_req_addr, rst ? RST_PC : m_fetch);
            check("mon_inst_valid", 64'(inst_valid), 64'(e_iv));
            if (e_iv) begin
                check("mon_inst_pc", inst_pc, m_pcs[0]);
                check("mon_inst_data", 64'(inst_data), 64'(m_data[0]));
            end
            check("mon_occupancy", 64'(occupancy), rst ? 64'd0 : 64'(m_pcs.size()));
            fire    = e_req && imem_req_ready;
            pop     = e_iv && inst_ready;
            resp    = imem_resp_valid;
            s_rdata = imem_resp_data;
            s_rst   = rst;
            s_redir = redirect_valid;
            s_rpc   = redirect_pc;
            @(posedge clk);
            if (s_rst) begin
                m_pcs.delete();
                m_data.delete();
                m_fetch  = RST_PC;
                m_drop   = 0;
                mem_q.delete();
                last_due = -1;
                n_fire   = 0;
            end else if (s_redir) begin
                m_drop = m_drop + pending - (resp ? 1 : 0);
                m_pcs.delete();
                m_data.delete();
                m_fetch = s_rpc & ~64'd3;
            end else begin
                if (resp) begin
                    if (m_drop > 0) m_drop--;
                    else if (pending > 0) m_data.push_back(s_rdata);
                end
                if (pop) begin
                    void'(m_pcs.pop_front());
                    void'(m_data.pop_front());
                end
                if (fire) begin
                    r.addr = m_fetch;
                    r.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                    last_due = r.due;
                    mem_q.push_back(r);
                    m_pcs.push_back(m_fetch);
                    m_fetch = m_fetch + 64'd4;
                    n_fire++;
                end
            end
            cyc++;
            #1;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                r = mem_q.pop_front();
                imem_resp_valid = 1'b1;
                imem_resp_data  = word(r.addr);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        #3;
    endtask

    task automatic wait_inst(input string name, input logic [63:0] exp_pc);
        int k = 0;
        while (!inst_valid && k < 40) begin
            next_cycle();
            k++;
        end
        check({name, "_seen"}, 64'(inst_valid), 64'd1);
        check({name, "_pc"}, inst_pc, exp_pc);
        check({name, "_data"}, 64'(inst_data), 64'(word(exp_pc)));
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
        repeat (3) @(negedge clk);
        #3;
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_req_addr", imem_req_addr, 64'h8000_0000);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);

        // Streaming at one instruction per cycle.
        @(negedge clk); rst = 1'b0; #3;
        check("t1_addr0", imem_req_addr, 64'h8000_0000);
        check("t1_req0", 64'(imem_req_valid), 64'd1);
        next_cycle();
        check("t1_addr1", imem_req_addr, 64'h8000_0004);
        next_cycle();
        check("t1_first_valid", 64'(inst_valid), 64'd1);
        check("t1_first_pc", inst_pc, 64'h8000_0000);
        check("t1_first_data", 64'(inst_data), 64'(word(64'h8000_0000)));
        check("t1_addr2", imem_req_addr, 64'h8000_0008);
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            check("t1_stream_valid", 64'(inst_valid), 64'd1);
            check("t1_stream_pc", inst_pc, 64'h8000_0004 + 64'(4 * i));
        end

        // ID stalled: ring fills after four requests.
        @(negedge clk); rst = 1'b1; inst_ready = 1'b0;
        @(negedge clk); rst = 1'b0;
        repeat (8) @(negedge clk);
        #3;
        check("t2_occupancy_full", 64'(occupancy), 64'd4);
        check("t2_req_blocked", 64'(imem_req_valid), 64'd0);
        check("t2_req_count", 64'(n_fire), 64'd4);
        @(negedge clk); inst_ready = 1'b1; #3;
        check("t2_pop0_pc", inst_pc, 64'h8000_0000);
        check("t2_bubble", 64'(imem_req_valid), 64'd0);
        next_cycle();
        check("t2_pop1_pc", inst_pc, 64'h8000_0004);
        check("t2_resume_addr", imem_req_addr, 64'h8000_0010);
        check("t2_resume_valid", 64'(imem_req_valid), 64'd1);
        next_cycle();
        check("t2_pop2_pc", inst_pc, 64'h8000_0008);
        next_cycle();
        check("t2_pop3_pc", inst_pc, 64'h8000_000C);

        // Redirect with two responses outstanding.
        @(negedge clk); rst = 1'b1; lat = 3;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
        @(negedge clk); redirect_valid = 1'b0; #3;
        check("t3_target_addr", imem_req_addr, 64'h8000_0100);
        check("t3_target_req", 64'(imem_req_valid), 64'd1);
        wait_inst("t3_first", 64'h8000_0100);

        // Redirect coinciding with the only outstanding response.
        @(negedge clk); rst = 1'b1; lat = 2;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); imem_req_ready = 1'b0;
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        @(negedge clk); redirect_valid = 1'b0; imem_req_ready = 1'b1; #3;
        wait_inst("t4_first", 64'h8000_2000);

        // Two redirects with three responses in flight.
        @(negedge clk); rst = 1'b1; lat = 4;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
        @(negedge clk); redirect_valid = 1'b0;
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
        @(negedge clk); redirect_valid = 1'b0; #3;
        wait_inst("t5_first", 64'h8000_3000);
        next_cycle();
        check("t5_second_pc", inst_pc, 64'h8000_3004);

        // Reset with a full ring and two responses in flight.
        @(negedge clk); rst = 1'b1; lat = 6; inst_ready = 1'b0;
        @(negedge clk); rst = 1'b0;
        repeat (7) @(negedge clk);
        #3;
        check("t6_full_before_rst", 64'(occupancy), 64'd4);
        @(negedge clk); rst = 1'b1; #3;
        check("t6_rst_inst_valid", 64'(inst_valid), 64'd0);
        check("t6_rst_occupancy", 64'(occupancy), 64'd0);
        @(negedge clk); rst = 1'b0; inst_ready = 1'b1; #3;
        check("t6_after_inst_valid", 64'(inst_valid), 64'd0);
        check("t6_after_occupancy", 64'(occupancy), 64'd0);
        check("t6_after_addr", imem_req_addr, 64'h8000_0000);
        check("t6_after_req", 64'(imem_req_valid), 64'd1);
        wait_inst("t6_first", 64'h8000_0000);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
